// File: rtl/traffic_light_ctrl.sv
// Traffic-light phase controller: green/yellow/red with BCD countdown, tick prescaler,
// pedestrian shortening, hold/freeze and night flashing mode.
module traffic_light_ctrl #(
   parameter int unsigned CLK_DIV     = 50000000,
   parameter int unsigned GREEN_TIME  = 42,
   parameter int unsigned YELLOW_TIME = 3,
   parameter int unsigned RED_TIME    = 36,
   parameter int unsigned PED_MIN     = 5
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ped_req,
   input  logic       hold,
   input  logic       night,
   output logic       led_red,
   output logic       led_yellow,
   output logic       led_green,
   output logic [1:0] phase,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       blank
);

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      RED    = 2'b10,
      FLASH  = 2'b11
   } phase_t;

   function automatic logic [7:0] to_bcd(input int unsigned v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] c);
      if (c[3:0] == 4'd0) return {c[7:4] - 4'd1, 4'd9};
      else                return {c[7:4], c[3:0] - 4'd1};
   endfunction

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_TIME);
   localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_TIME);
   localparam logic [7:0] RED_BCD    = to_bcd(RED_TIME);
   localparam logic [7:0] PED_BCD    = to_bcd(PED_MIN);

   phase_t          state;
   logic [7:0]      count;
   logic [PW-1:0]   presc;
   logic            ped_pending;
   logic            flash_tog;
   logic            tick;

   assign tick     = !hold && (presc == PRESC_LAST);
   assign phase    = state;
   assign bcd_tens = count[7:4];
   assign bcd_ones = count[3:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= GREEN;
         count       <= GREEN_BCD;
         presc       <= '0;
         ped_pending <= 1'b0;
         flash_tog   <= 1'b0;
         blank       <= 1'b0;
         led_green   <= 1'b1;
         led_yellow  <= 1'b0;
         led_red     <= 1'b0;
      end else begin
         if (!hold)
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);

         if (ped_req && (state == GREEN || state == YELLOW))
            ped_pending <= 1'b1;

         // Later clears of ped_pending in this block override the set above.
         if (tick) begin
            if (state == FLASH) begin
               if (night) begin
                  flash_tog  <= ~flash_tog;
                  led_yellow <= ~flash_tog;
               end else begin
                  state       <= RED;
                  count       <= RED_BCD;
                  blank       <= 1'b0;
                  flash_tog   <= 1'b0;
                  ped_pending <= 1'b0;
                  led_red     <= 1'b1;
                  led_yellow  <= 1'b0;
                  led_green   <= 1'b0;
               end
            end else if (night) begin
               state       <= FLASH;
               count       <= '0;
               blank       <= 1'b1;
               flash_tog   <= 1'b1;
               ped_pending <= 1'b0;
               led_red     <= 1'b0;
               led_yellow  <= 1'b1;
               led_green   <= 1'b0;
            end else if (count == '0) begin
               case (state)
                  GREEN: begin
                     state      <= YELLOW;
                     count      <= YELLOW_BCD;
                     led_green  <= 1'b0;
                     led_yellow <= 1'b1;
                  end
                  YELLOW: begin
                     state       <= RED;
                     count       <= RED_BCD;
                     ped_pending <= 1'b0;
                     led_yellow  <= 1'b0;
                     led_red     <= 1'b1;
                  end
                  default: begin
                     state     <= GREEN;
                     count     <= GREEN_BCD;
                     led_red   <= 1'b0;
                     led_green <= 1'b1;
                  end
               endcase
            end else if (state == GREEN && ped_pending && count > PED_BCD) begin
               count <= PED_BCD;
            end else begin
               count <= bcd_dec(count);
            end
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with CLK_DIV=4, GREEN=12, YELLOW=3, RED=10, PED_MIN=5.
module tb_traffic_light_ctrl;

   localparam logic [1:0] PG = 2'b00, PY = 2'b01, PR = 2'b10, PF = 2'b11;

   logic       clk = 1'b0;
   logic       rstn;
   logic       ped_req = 1'b0;
   logic       hold = 1'b0;
   logic       night = 1'b0;
   logic       led_red, led_yellow, led_green, blank;
   logic [1:0] phase;
   logic [3:0] bcd_tens, bcd_ones;

   int unsigned checks = 0;
   int unsigned errors = 0;

   traffic_light_ctrl #(
      .CLK_DIV(4), .GREEN_TIME(12), .YELLOW_TIME(3), .RED_TIME(10), .PED_MIN(5)
   ) dut (
      .clk(clk), .rstn(rstn), .ped_req(ped_req), .hold(hold), .night(night),
      .led_red(led_red), .led_yellow(led_yellow), .led_green(led_green),
      .phase(phase), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .blank(blank)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observed();
      return 32'({phase, bcd_tens, bcd_ones, led_red, led_yellow, led_green, blank});
   endfunction

   function automatic logic [31:0] expect_norm(input logic [1:0] ph, input int v);
      return 32'({ph, 4'(v / 10), 4'(v % 10), ph == PR, ph == PY, ph == PG, 1'b0});
   endfunction

   function automatic logic [31:0] expect_flash(input logic tog);
      return 32'({PF, 8'h00, 1'b0, tog, 1'b0, 1'b1});
   endfunction

   // One full tick period; caller is always 1 time unit after a tick edge.
   task automatic tick1();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic ped_tick();
      ped_req = 1'b1;
      @(posedge clk);
      #1 ped_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [1:0] ph, input int from, input int to);
      for (int v = from; v >= to; v--) begin
         tick1();
         check(tag, observed(), expect_norm(ph, v));
      end
   endtask

   initial begin
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("reset", observed(), expect_norm(PG, 12));
      rstn = 1'b1;
      #1;

      // free run through a complete cycle
      run("run_g", PG, 11, 0);
      run("run_y", PY, 3, 0);
      run("run_r", PR, 10, 0);
      run("run_g12", PG, 12, 12);

      // pedestrian shortening at 11, none at 03
      run("ped_g11", PG, 11, 11);
      ped_tick();
      check("ped_short", observed(), expect_norm(PG, 5));
      run("ped_after", PG, 4, 0);
      run("ped_y", PY, 3, 0);
      run("ped_r", PR, 10, 0);
      run("ped_g2", PG, 12, 3);
      ped_tick();
      check("ped_noshort", observed(), expect_norm(PG, 2));
      run("ped_g2_end", PG, 1, 0);
      run("ped_y2", PY, 3, 0);

      // request during red is ignored
      run("red_pre", PR, 10, 7);
      ped_tick();
      check("red_ped", observed(), expect_norm(PR, 6));
      run("red_post", PR, 5, 0);
      run("green_full", PG, 12, 0);
      run("y3", PY, 3, 0);
      run("r3", PR, 10, 0);
      run("g_to8", PG, 12, 8);

      // night flashing
      night = 1'b1;
      tick1();
      check("flash_in", observed(), expect_flash(1'b1));
      tick1();
      check("flash_t0", observed(), expect_flash(1'b0));
      tick1();
      check("flash_t1", observed(), expect_flash(1'b1));
      night = 1'b0;
      tick1();
      check("flash_out", observed(), expect_norm(PR, 10));

      // hold freezes count and prescaler (prescaler left at 2)
      run("pre_hold", PR, 9, 6);
      repeat (2) @(posedge clk);
      #1 hold = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("hold_frozen", observed(), expect_norm(PR, 6));
      hold = 1'b0;
      @(posedge clk);
      #1;
      check("hold_rel1", observed(), expect_norm(PR, 6));
      @(posedge clk);
      #1;
      check("hold_rel2", observed(), expect_norm(PR, 5));

      // asynchronous reset mid-yellow
      run("pre_rst_r", PR, 4, 0);
      run("pre_rst_g", PG, 12, 0);
      run("pre_rst_y", PY, 3, 2);
      #2 rstn = 1'b0;
      #1;
      check("async_rst", observed(), expect_norm(PG, 12));
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_tick", observed(), expect_norm(PG, 12));
      @(posedge clk);
      #1;
      check("rst_first_tick", observed(), expect_norm(PG, 11));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised traffic-light phase controller. Adds a yellow phase, per-phase durations, a built-in 1-tick prescaler, pedestrian-request shortening, a hold/freeze input and a night flashing mode. Counts down each phase directly in two BCD digits. The top level feeds the digits to the existing seven-segment decoder instances and drives the board LEDs from the lamp outputs.

Parameters:
CLK_DIV, 50000000, clk cycles per countdown tick (>=1; 1 = tick every cycle)
GREEN_TIME, 42, green start value in ticks (0..99)
YELLOW_TIME, 3, yellow start value in ticks (0..99)
RED_TIME, 36, red start value in ticks (0..99)
PED_MIN, 5, green remaining-count floor applied on a pedestrian request (0..99, < GREEN_TIME)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
ped_req  in  1  pedestrian request, level or pulse, synchronous to clk
hold  in  1  1 = freeze prescaler and countdown
night  in  1  1 = request night flashing mode
led_red  out  1  red lamp
led_yellow  out  1  yellow lamp
led_green  out  1  green lamp
phase  out  2  00 GREEN, 01 YELLOW, 10 RED, 11 FLASH
bcd_tens  out  4  countdown tens digit, BCD
bcd_ones  out  4  countdown ones digit, BCD
blank  out  1  1 = display must be blanked (FLASH)

Behaviour:
- All state is in clk-edge flops. rstn low asynchronously forces: phase=GREEN, count=GREEN_TIME in BCD, led_green=1, led_red=0, led_yellow=0, blank=0, prescaler=0, ped_pending=0, flash toggle=0.
- Prescaler: counts 0..CLK_DIV-1 and wraps to 0. tick is high for one cycle when prescaler==CLK_DIV-1. While hold=1, prescaler and tick are frozen; hold released resumes from the frozen value.
- Count register: {bcd_tens,bcd_ones}, always valid BCD. Decrement: ones==0 -> ones=9, tens=tens-1; else ones=ones-1. No other arithmetic.
- Lamps are registered and decoded from the state: GREEN -> green only; YELLOW -> yellow only; RED -> red only; FLASH -> led_yellow = flash toggle, others 0.
- Transitions occur only on tick cycles. Non-tick cycles hold all state except the prescaler and ped_pending.
- On tick in a normal phase:
  - night=1 -> FLASH, count=00, blank=1, flash toggle=1.
  - else count==00 -> next phase and load its start value: GREEN->YELLOW (YELLOW_TIME), YELLOW->RED (RED_TIME), RED->GREEN (GREEN_TIME).
  - else GREEN with ped_pending=1 and count>PED_MIN -> count=PED_MIN.
  - else decrement.
- Each phase shows its start value down to 00, so a phase lasts TIME+1 ticks.
- FLASH, on tick: night=1 -> invert flash toggle; night=0 -> RED with RED_TIME, blank=0, flash toggle=0. Exit is always to RED.
- ped_pending:
  - Set on any cycle with ped_req=1 while phase is GREEN or YELLOW.
  - Cleared on entry to RED and on entry to FLASH.
  - ped_req is ignored during RED and FLASH.
  - If set and clear coincide, clear wins.
- Priority on a tick: night > phase expiry > pedestrian shortening > decrement.
- hold=1 blocks every transition, including night entry and exit. ped_req is still latched while hold=1.
- Outputs change one cycle after the tick cycle; no combinational path from inputs to outputs.
- Reset mid-phase: immediate return to the reset values; the next tick occurs CLK_DIV cycles after rstn deasserts.

Test Plan:
Bench parameters for all cases: CLK_DIV=4, GREEN_TIME=12, YELLOW_TIME=3, RED_TIME=10, PED_MIN=5.
1. Reset, then free-run -> GREEN digits show 1,2 then 1,1 ... 0,0 (13 ticks = 52 clk), then YELLOW 03..00, then RED 10..00, then GREEN 12. Each tens borrow goes 10 -> 09.
2. ped_req pulse for 1 cycle at GREEN count 11 -> next tick count=05, then 04..00, then YELLOW. A second pulse at count 03 -> no shortening.
3. ped_req during RED count 07 -> ignored; the following GREEN runs the full 12..00.
4. night=1 at GREEN count 08 -> next tick: phase=11, blank=1, led_yellow=1, then toggles every tick. night=0 -> next tick: RED, count 10, blank=0.
5. hold=1 for 20 clk at RED count 06 -> count and prescaler frozen, lamps unchanged. After release, the next tick arrives after the remaining prescaler cycles.
6. rstn low for 1 cycle mid-YELLOW at count 02 -> outputs return to GREEN and 12 asynchronously. The first tick follows 4 clk after release.
